// File: rtl/regfile_wb_arbiter.sv
// Owns the register file's single write port: round-robin arbitration among writeback
// sources, plus a clear sequencer that zeroes x1..x31 after reset or on clear_start.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      clear_start,
   output logic                      busy,
   output logic                      write_enable,
   output logic [ADDR_W-1:0]         address3,
   output logic [DATA_W-1:0]         write_data
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};
   localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]    PTR_WRAP  = (PTR_W + 1)'(NUM_REQ);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic [PTR_W-1:0]  ptr_reg, ptr_next;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] data_reg, data_next;

   logic [ADDR_W-1:0] addr_arr [NUM_REQ];
   logic [DATA_W-1:0] data_arr [NUM_REQ];

   logic              found;
   logic [PTR_W-1:0]  winner;
   logic [PTR_W:0]    idx;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Search starts at the pointer; wrap by explicit compare so odd NUM_REQ works.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr_reg} + (PTR_W + 1)'(k);
         if (idx >= PTR_WRAP) begin
            idx = idx - PTR_WRAP;
         end
         if (!found && req_valid[idx[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_reg == RUN && !clear_start && found) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ptr_next   = ptr_reg;
      we_next    = 1'b0;
      addr_next  = addr_reg;
      data_next  = data_reg;
      case (state_reg)
         CLEAR: begin
            we_next   = 1'b1;
            addr_next = cnt_reg;
            data_next = '0;
            if (cnt_reg == CNT_LAST) begin
               state_next = RUN;
               cnt_next   = CNT_FIRST;
            end else begin
               cnt_next = cnt_reg + ADDR_W'(1);
            end
         end
         RUN: begin
            if (clear_start) begin
               state_next = CLEAR;
               cnt_next   = CNT_FIRST;
            end else if (found) begin
               // Address 0 is still consumed, but x0 is never written.
               addr_next = addr_arr[winner];
               data_next = data_arr[winner];
               we_next   = (addr_arr[winner] != '0);
               ptr_next  = (winner == PTR_MAX) ? '0 : winner + PTR_W'(1);
            end
         end
         default: begin
            state_next = CLEAR;
            cnt_next   = CNT_FIRST;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= CLEAR;
         cnt_reg   <= CNT_FIRST;
         ptr_reg   <= '0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ptr_reg   <= ptr_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         data_reg  <= data_next;
      end
   end

   assign busy         = (state_reg == CLEAR);
   assign write_enable = we_reg;
   assign address3     = addr_reg;
   assign write_data   = data_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected grants and writes,
// a negedge monitor pops and compares them as the DUT produces accepts and write-port activity.
module tb_regfile_wb_arbiter;
   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 32;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      clear_start;
   logic                      busy;
   logic                      write_enable;
   logic [ADDR_W-1:0]         address3;
   logic [DATA_W-1:0]         write_data;

   regfile_wb_arbiter #(
      .NUM_REQ(NUM_REQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .clear_start (clear_start),
      .busy        (busy),
      .write_enable(write_enable),
      .address3    (address3),
      .write_data  (write_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t               exp_wr_q[$];
   int                exp_gnt_q[$];
   logic [DATA_W-1:0] rf [32];
   int                n_checks = 0;
   int                n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic wr_t mk_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   task automatic push_clear();
      for (int a = 1; a < 32; a++) begin
         exp_wr_q.push_back(mk_wr(ADDR_W'(a), '0));
      end
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_valid[i] = 1'b1;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Register file model: commits whatever the write port presents at each edge.
   always @(posedge clk) begin
      if (write_enable) begin
         rf[address3] <= write_data;
      end
   end

   // Monitor: compares accepts and write-port transactions against the queues.
   always @(negedge clk) begin
      wr_t w;
      int  g;
      if (rst_n) begin
         check("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               n_checks++;
               if (exp_gnt_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL grant_unexpected: got requester %0d expected none", i);
               end else begin
                  n_checks--;
                  g = exp_gnt_q.pop_front();
                  check("grant_idx", 64'(i), 64'(g));
               end
            end
         end
         if (write_enable) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
               n_fail++;
               $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h expected none",
                        address3, write_data);
            end else begin
               n_checks--;
               w = exp_wr_q.pop_front();
               check("wr_addr", 64'(address3), 64'(w.addr));
               check("wr_data", 64'(write_data), 64'(w.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit hit;
      rst_n       = 1'b1;
      req_valid   = '0;
      req_addr    = '0;
      req_data    = '0;
      clear_start = 1'b0;
      for (int r = 0; r < 32; r++) rf[r] = '0;

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check("rst_we",    64'(write_enable), 64'(0));
      check("rst_addr",  64'(address3),     64'(0));
      check("rst_data",  64'(write_data),   64'(0));
      check("rst_busy",  64'(busy),         64'(1));
      check("rst_ready", 64'(req_ready),    64'(0));

      // Clear after reset release: edges 1..31 load x1..x31
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push_clear();
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("clear_busy", 64'(busy), 64'(k < 31));
         check("clear_we",   64'(write_enable), 64'(1));
      end
      @(posedge clk);
      @(negedge clk);
      check("post_clear_we",   64'(write_enable), 64'(0));
      check("post_clear_busy", 64'(busy),         64'(0));

      // Single request from requester 1
      to_drive();
      set_req(1, 5'd5, 32'hDEADBEEF);
      exp_gnt_q.push_back(1);
      exp_wr_q.push_back(mk_wr(5'd5, 32'hDEADBEEF));
      @(negedge clk);
      check("single_ready", 64'(req_ready), 64'(3'b010));
      to_drive();
      req_valid[1] = 1'b0;
      @(negedge clk);
      check("single_we", 64'(write_enable), 64'(1));
      to_drive();
      check("rf_x5", 64'(rf[5]), 64'(32'hDEADBEEF));

      // Address zero from requester 0: consumed, no write
      set_req(0, 5'd0, 32'h1234);
      exp_gnt_q.push_back(0);
      @(negedge clk);
      check("zero_ready", 64'(req_ready), 64'(3'b001));
      to_drive();
      req_valid[0] = 1'b0;
      @(negedge clk);
      check("zero_we",   64'(write_enable), 64'(0));
      check("zero_addr", 64'(address3),     64'(0));
      check("zero_data", 64'(write_data),   64'(32'h1234));
      to_drive();
      check("rf_x0", 64'(rf[0]), 64'(0));

      // Requester 2 alone (pointer at 1 skips idle requesters)
      set_req(2, 5'd7, 32'h77);
      exp_gnt_q.push_back(2);
      exp_wr_q.push_back(mk_wr(5'd7, 32'h77));
      @(negedge clk);
      check("r2_ready", 64'(req_ready), 64'(3'b100));
      to_drive();
      req_valid[2] = 1'b0;

      // Fairness: pointer at 0, all three continuously valid
      set_req(0, 5'd1, 32'hA1);
      set_req(1, 5'd2, 32'hA2);
      set_req(2, 5'd3, 32'hA3);
      for (int j = 0; j < 6; j++) begin
         exp_gnt_q.push_back(j % 3);
         exp_wr_q.push_back(mk_wr(ADDR_W'(j % 3 + 1), DATA_W'(32'hA1 + j % 3)));
      end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("fair_ready", 64'(req_ready), 64'(3'b001 << (j % 3)));
         if (j > 0) check("fair_b2b_we", 64'(write_enable), 64'(1));
         to_drive();
      end
      req_valid = '0;

      // clear_start while requester 2 is pending: clear wins
      clear_start = 1'b1;
      set_req(2, 5'd9, 32'h99);
      @(negedge clk);
      check("clrs_ready_blocked", 64'(req_ready), 64'(0));
      check("clrs_busy_run",      64'(busy),      64'(0));
      to_drive();
      clear_start = 1'b0;
      push_clear();
      exp_wr_q.push_back(mk_wr(5'd9, 32'h99));
      exp_gnt_q.push_back(2);
      for (int k = 0; k < 31; k++) begin
         @(negedge clk);
         check("clrs_busy",  64'(busy),      64'(1));
         check("clrs_ready", 64'(req_ready), 64'(0));
         if (k == 0) check("clrs_we_entry", 64'(write_enable), 64'(0));
      end
      @(negedge clk);
      check("clrs_resume_busy",  64'(busy),      64'(0));
      check("clrs_resume_ready", 64'(req_ready), 64'(3'b100));
      to_drive();
      req_valid[2] = 1'b0;
      @(negedge clk);
      to_drive();
      check("rf_x9", 64'(rf[9]), 64'(32'h99));
      check("rf_x5_cleared", 64'(rf[5]), 64'(0));
      check("rf_x7_cleared", 64'(rf[7]), 64'(0));

      // Reset asserted while address3=10 during a clear
      clear_start = 1'b1;
      to_drive();
      clear_start = 1'b0;
      push_clear();
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(negedge clk);
         if (write_enable && address3 == 5'd10) hit = 1'b1;
      end
      check("midclr_reached_10", 64'(hit), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      check("midclr_rst_we",    64'(write_enable), 64'(0));
      check("midclr_rst_addr",  64'(address3),     64'(0));
      check("midclr_rst_data",  64'(write_data),   64'(0));
      check("midclr_rst_busy",  64'(busy),         64'(1));
      check("midclr_rst_ready", 64'(req_ready),    64'(0));
      exp_wr_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      push_clear();
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("reclear_busy", 64'(busy), 64'(k < 31));
         check("reclear_we",   64'(write_enable), 64'(1));
      end
      @(posedge clk);
      @(negedge clk);
      check("reclear_done_we", 64'(write_enable), 64'(0));
      check("rf_x10_cleared", 64'(rf[10]), 64'(0));

      check("wr_q_drained",  64'(exp_wr_q.size()),  64'(0));
      check("gnt_q_drained", 64'(exp_gnt_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
